scr1_dmi_chain: RTL and testbench
=================================

# scr1_dmi_chain

SysCLK-domain DMI/DTMCS scan-chain engine sitting directly downstream of the TAPC clock-domain synchronizer. It consumes the synchronized chain-select, chain-id, capture/shift/update strobes and TDI bit, and returns the TDO bit. It implements the RISC-V Debug Transport Module DTMCS and DMI data registers, and turns each DMI update into a request/response transaction toward the Debug Module.

## Interface
Parameters:
- DMI_ABITS, 7: DMI address width.
- DMI_DATAW, 32: DMI data width.
- DTM_IDLE_HINT, 1: value reported in dtmcs.idle.

Ports:
- clk  in  1  system clock (SysCLK).
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other reset.
- dmi_ch_sel_core  in  1  chain selected (level).
- dmi_ch_id_core  in  2  chain id: 2'd1 = DTMCS, 2'd2 = DMI; other values select nothing.
- dmi_ch_capture_core / dmi_ch_shift_core / dmi_ch_update_core  in  1  one-cycle strobes.
- dmi_ch_tdi_core  in  1  TDI bit, valid with the shift strobe.
- dmi_ch_tdo_core  out  1  TDO bit = shift_reg[0], registered.
- dmi_req  out  1  request to DM; held until dmi_resp.
- dmi_wr  out  1  1 = write, 0 = read; stable while dmi_req.
- dmi_addr  out  DMI_ABITS  request address; stable while dmi_req.
- dmi_wdata  out  DMI_DATAW  write data; stable while dmi_req.
- dmi_resp  in  1  one-cycle completion pulse from DM.
- dmi_rdata  in  DMI_DATAW  read data, valid with dmi_resp.

## Operation
- Strobes act only when dmi_ch_sel_core = 1 and the id is 1 or 2. Otherwise they are ignored.
- Chain length: L = 32 for DTMCS and L = DMI_ABITS + DMI_DATAW + 2 = 41 for DMI. There is one 41-bit shift_reg.
- DMI layout, LSB first: op[1:0], data[33:2], addr[40:34].
- Capture, DMI chain: shift_reg ← {last_addr, last_rdata, status}.
  - status = 2'd3 if sticky_busy is set or the FSM is in REQ.
  - status = 2'd0 otherwise.
- Capture, DTMCS chain: shift_reg ← {9'b0, zeros[31:18], 0, 0, 1'b0, DTM_IDLE_HINT[2:0], dmistat, abits = 6'd7, version = 4'd1}.
  - The layout follows RISC-V debug 0.13.
  - dmistat = 2'd3 if sticky_busy is set, else 0.
- Shift: shift_reg ← shift_reg >> 1, with tdi inserted at bit L-1. Bits at L and above are don't-care.
- Update, DTMCS chain: if bit16 (dmireset) or bit17 (dmihardreset) is set, sticky_busy is cleared. Nothing else is writable.
- Update, DMI chain, decided in this order:
  - If sticky_busy is set: no action.
  - Else if the FSM is in REQ: sticky_busy is set and the update is dropped.
  - Else by op:
    - op = 1 (read): latch addr into last_addr, drive dmi_wr = 0, enter REQ.
    - op = 2 (write): latch addr into last_addr, latch data into wdata, drive dmi_wr = 1, enter REQ.
    - op = 0 or 3: no request.
- FSM states:
  - IDLE: dmi_req = 0.
  - REQ: dmi_req = 1.
  - REQ→IDLE on dmi_resp. On a read, last_rdata ← dmi_rdata. On a write, last_rdata is unchanged.
- dmi_resp while in IDLE is ignored.
- Strobe priority, if more than one fires in a cycle (illegal from TAP, but defined): update > capture > shift.
- Update and dmi_resp in the same cycle: the response completes first. The FSM is therefore IDLE when the update is evaluated, so the update is accepted and no busy is raised.
- Reset values:
  - All outputs 0.
  - shift_reg, last_addr, last_rdata, wdata = 0; sticky_busy = 0; FSM = IDLE.
- Reset during REQ drops dmi_req immediately. A late dmi_resp after reset is ignored.

## Timing
- All state is registered on posedge clk.
- dmi_ch_tdo_core changes the cycle after a capture or shift strobe.
- An update strobe in cycle N gives dmi_req = 1 in cycle N+1.
- dmi_resp in cycle M gives dmi_req = 0 in cycle M+1, with last_rdata updated in M+1.
- The DM may respond in the same cycle dmi_req rises or any cycle later. There is no timeout.
- Strobes arrive at most once per two clk cycles, so no back-to-back handling is required.

## Structure
- Shared package scr1_dmi_pkg holds:
  - chain-id constants SCR1_DMI_CH_DTMCS = 2'd1 and SCR1_DMI_CH_DMI = 2'd2;
  - op and status enums;
  - the FSM state enum {DMI_IDLE, DMI_REQ};
  - the DTMCS field offsets and version/abits constants.
- Single module, no sub-modules. The shift register and the FSM live in separate always_ff blocks.

## Test plan
- Reset, then capture+shift 32 bits on DTMCS → TDO stream is 0x00001071, LSB first (version = 1, abits = 7, idle = 1).
- DMI write addr = 0x10, data = 0x1 → dmi_req rises 1 cycle after update with dmi_wr = 1, dmi_addr = 0x10, dmi_wdata = 0x1. DM responds 3 cycles later → dmi_req falls the next cycle.
- DMI read addr = 0x11, DM returns 0xDEADBEEF → next DMI capture shifts out op = 0, data = 0xDEADBEEF, addr = 0x11.
- Second DMI update while the first request is unacknowledged → no new request. Capture reports op = 3. DTMCS capture shows dmistat = 3. Later updates are ignored until a DTMCS update with bit16 = 1 clears busy.
- Update coincident with dmi_resp → the new request is issued in the next cycle and no busy is flagged. Strobes with dmi_ch_sel_core = 0 or id = 0 → shift_reg unchanged.
- Assert rst_n low during REQ → dmi_req = 0 and all outputs 0 immediately. A following dmi_resp leaves last_rdata = 0.

Source files
------------

// File: rtl/scr1_dmi_pkg.sv
// Shared definitions for the SysCLK-side DTMCS/DMI scan-chain engine.
package scr1_dmi_pkg;

  localparam logic [1:0] SCR1_DMI_CH_DTMCS = 2'd1;
  localparam logic [1:0] SCR1_DMI_CH_DMI   = 2'd2;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSV   = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_ST_OK   = 2'd0,
    DMI_ST_RSV  = 2'd1,
    DMI_ST_FAIL = 2'd2,
    DMI_ST_BUSY = 2'd3
  } dmi_status_e;

  typedef enum logic {
    DMI_IDLE = 1'b0,
    DMI_REQ  = 1'b1
  } dmi_fsm_e;

  // dtmcs field offsets (RISC-V debug 0.13 layout)
  localparam int DTMCS_VERSION_LSB  = 0;
  localparam int DTMCS_ABITS_LSB    = 4;
  localparam int DTMCS_DMISTAT_LSB  = 10;
  localparam int DTMCS_IDLE_LSB     = 12;
  localparam int DTMCS_DMIRESET     = 16;
  localparam int DTMCS_DMIHARDRESET = 17;

  localparam logic [3:0] DTMCS_VERSION = 4'd1;
  localparam logic [5:0] DTMCS_ABITS   = 6'd7;

  // Build the read-only dtmcs capture word.
  function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                             input logic [1:0] dmistat);
    logic [31:0] w;
    w = '0;
    w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
    w[DTMCS_ABITS_LSB   +: 6] = DTMCS_ABITS;
    w[DTMCS_DMISTAT_LSB +: 2] = dmistat;
    w[DTMCS_IDLE_LSB    +: 3] = idle;
    return w;
  endfunction

endpackage

// File: rtl/scr1_dmi_chain.sv
// DTMCS/DMI data registers and DMI request engine in the SysCLK domain.
//
// state    | meaning
// DMI_IDLE | no outstanding request, dmi_req = 0
// DMI_REQ  | request presented to DM, waiting for dmi_resp
module scr1_dmi_chain
  import scr1_dmi_pkg::*;
#(
  parameter int DMI_ABITS     = 7,
  parameter int DMI_DATAW     = 32,
  parameter int DTM_IDLE_HINT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dmi_ch_sel_core,
  input  logic [1:0]           dmi_ch_id_core,
  input  logic                 dmi_ch_capture_core,
  input  logic                 dmi_ch_shift_core,
  input  logic                 dmi_ch_update_core,
  input  logic                 dmi_ch_tdi_core,
  output logic                 dmi_ch_tdo_core,
  output logic                 dmi_req,
  output logic                 dmi_wr,
  output logic [DMI_ABITS-1:0] dmi_addr,
  output logic [DMI_DATAW-1:0] dmi_wdata,
  input  logic                 dmi_resp,
  input  logic [DMI_DATAW-1:0] dmi_rdata
);

  localparam int SR_W = DMI_ABITS + DMI_DATAW + 2;
  localparam logic [2:0] IDLE_HINT = 3'(DTM_IDLE_HINT);

  logic [SR_W-1:0]      shift_reg;
  logic [SR_W-1:0]      sr_shifted;
  logic [SR_W-1:0]      dtmcs_cap;
  logic [SR_W-1:0]      dmi_cap;
  logic [DMI_DATAW-1:0] last_rdata;
  logic                 sticky_busy;
  dmi_fsm_e             state;

  logic    ch_dtmcs, ch_dmi, ch_act;
  logic    upd, cap, shf;
  logic    resp_done, req_busy;
  dmi_op_e upd_op;
  logic [1:0] dmi_status;

  assign ch_dtmcs = dmi_ch_sel_core && (dmi_ch_id_core == SCR1_DMI_CH_DTMCS);
  assign ch_dmi   = dmi_ch_sel_core && (dmi_ch_id_core == SCR1_DMI_CH_DMI);
  assign ch_act   = ch_dtmcs || ch_dmi;

  // update wins over capture, capture over shift
  assign upd = ch_act && dmi_ch_update_core;
  assign cap = ch_act && dmi_ch_capture_core && !dmi_ch_update_core;
  assign shf = ch_act && dmi_ch_shift_core && !dmi_ch_capture_core && !dmi_ch_update_core;

  // a response arriving with an update retires first, so it never counts as busy
  assign resp_done = (state == DMI_REQ) && dmi_resp;
  assign req_busy  = (state == DMI_REQ) && !dmi_resp;
  assign upd_op    = dmi_op_e'(shift_reg[1:0]);

  assign dmi_status = (sticky_busy || state == DMI_REQ) ? DMI_ST_BUSY : DMI_ST_OK;
  assign dmi_cap    = {dmi_addr, last_rdata, dmi_status};
  assign dmi_ch_tdo_core = shift_reg[0];

  // Capture and shift-in position depend on which chain is active.
  always_comb begin
    dtmcs_cap = '0;
    dtmcs_cap[31:0] = dtmcs_word(IDLE_HINT, sticky_busy ? 2'd3 : 2'd0);
    sr_shifted = shift_reg >> 1;
    if (ch_dmi) sr_shifted[SR_W-1] = dmi_ch_tdi_core;
    else        sr_shifted[31]     = dmi_ch_tdi_core;
  end

  // Shared 41-bit scan register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (cap) begin
      shift_reg <= ch_dmi ? dmi_cap : dtmcs_cap;
    end else if (shf) begin
      shift_reg <= sr_shifted;
    end
  end

  // Request FSM, sticky busy and DM-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DMI_IDLE;
      dmi_req     <= 1'b0;
      dmi_wr      <= 1'b0;
      dmi_addr    <= '0;
      dmi_wdata   <= '0;
      last_rdata  <= '0;
      sticky_busy <= 1'b0;
    end else begin
      if (resp_done) begin
        state   <= DMI_IDLE;
        dmi_req <= 1'b0;
        if (!dmi_wr) last_rdata <= dmi_rdata;
      end
      if (upd && ch_dtmcs &&
          (shift_reg[DTMCS_DMIRESET] || shift_reg[DTMCS_DMIHARDRESET])) begin
        sticky_busy <= 1'b0;
      end
      if (upd && ch_dmi && !sticky_busy) begin
        if (req_busy) begin
          sticky_busy <= 1'b1;
        end else if (upd_op == DMI_OP_READ) begin
          dmi_addr <= shift_reg[SR_W-1:DMI_DATAW+2];
          dmi_wr   <= 1'b0;
          dmi_req  <= 1'b1;
          state    <= DMI_REQ;
        end else if (upd_op == DMI_OP_WRITE) begin
          dmi_addr  <= shift_reg[SR_W-1:DMI_DATAW+2];
          dmi_wdata <= shift_reg[DMI_DATAW+1:2];
          dmi_wr    <= 1'b1;
          dmi_req   <= 1'b1;
          state     <= DMI_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmi_chain.sv
// Directed bench for scr1_dmi_chain: DTMCS/DMI scans, requests, busy, reset.
module tb_scr1_dmi_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  ch_id = 2'd0;
  logic        cap_s = 1'b0, sh_s = 1'b0, upd_s = 1'b0, tdi = 1'b0;
  logic        tdo;
  logic        dmi_req, dmi_wr;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        dmi_resp = 1'b0;
  logic [31:0] dmi_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_dmi_chain dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dmi_ch_sel_core     (sel),
    .dmi_ch_id_core      (ch_id),
    .dmi_ch_capture_core (cap_s),
    .dmi_ch_shift_core   (sh_s),
    .dmi_ch_update_core  (upd_s),
    .dmi_ch_tdi_core     (tdi),
    .dmi_ch_tdo_core     (tdo),
    .dmi_req             (dmi_req),
    .dmi_wr              (dmi_wr),
    .dmi_addr            (dmi_addr),
    .dmi_wdata           (dmi_wdata),
    .dmi_resp            (dmi_resp),
    .dmi_rdata           (dmi_rdata)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  // one strobe cycle followed by one idle cycle; returns at the negedge after sampling
  task automatic strobe(input logic c, input logic s, input logic u, input logic d);
    @(negedge clk);
    cap_s = c; sh_s = s; upd_s = u; tdi = d;
    @(negedge clk);
    cap_s = 1'b0; sh_s = 1'b0; upd_s = 1'b0;
  endtask

  task automatic scan(input logic [1:0] id, input int len, input logic do_cap,
                      input logic [40:0] din, output logic [40:0] dout);
    sel = 1'b1; ch_id = id; dout = '0;
    if (do_cap) strobe(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      strobe(1'b0, 1'b1, 1'b0, din[i]);
    end
  endtask

  task automatic update(input logic [1:0] id);
    sel = 1'b1; ch_id = id;
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic respond(input logic [31:0] rd);
    @(negedge clk);
    dmi_resp = 1'b1; dmi_rdata = rd;
    @(negedge clk);
    dmi_resp = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmi_req); end
    checks++; if ({dmi_wr, dmi_addr, dmi_wdata} !== 40'h0) begin errors++;
      $display("FAIL reset_outputs: got wr=%b addr=%h wdata=%h expected all 0", dmi_wr, dmi_addr, dmi_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dtmcs_capture;
    logic [40:0] d;
    scan(2'd1, 32, 1'b1, 41'h0, d);
    checks++; if (d[31:0] !== 32'h0000_1071) begin errors++;
      $display("FAIL dtmcs_capture: got %h expected 00001071", d[31:0]); end
  endtask

  task automatic test_dmi_write;
    logic [40:0] d;
    scan(2'd2, 41, 1'b1, {7'h10, 32'h1, 2'd2}, d);
    checks++; if (d !== 41'h0) begin errors++; $display("FAIL write_capture: got %h expected 0", d); end
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL write_req_pre: got %b expected 0", dmi_req); end
    update(2'd2);
    checks++; if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata} !== {1'b1, 1'b1, 7'h10, 32'h1}) begin errors++;
      $display("FAIL write_req: got req=%b wr=%b addr=%h wdata=%h expected 1 1 10 00000001",
               dmi_req, dmi_wr, dmi_addr, dmi_wdata); end
    repeat (2) @(negedge clk);
    checks++; if (dmi_req !== 1'b1) begin errors++; $display("FAIL write_req_hold: got %b expected 1", dmi_req); end
    respond(32'h0);
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL write_req_fall: got %b expected 0", dmi_req); end
  endtask

  task automatic test_dmi_read;
    logic [40:0] d;
    scan(2'd2, 41, 1'b1, {7'h11, 32'h0, 2'd1}, d);
    update(2'd2);
    checks++; if ({dmi_req, dmi_wr, dmi_addr} !== {1'b1, 1'b0, 7'h11}) begin errors++;
      $display("FAIL read_req: got req=%b wr=%b addr=%h expected 1 0 11", dmi_req, dmi_wr, dmi_addr); end
    // DM answers in the same cycle the request is first visible
    dmi_resp = 1'b1; dmi_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmi_resp = 1'b0;
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL read_req_fall: got %b expected 0", dmi_req); end
    respond(32'h7777_7777);  // stray response while idle
    scan(2'd2, 41, 1'b1, 41'h0, d);
    checks++; if (d !== {7'h11, 32'hDEAD_BEEF, 2'd0}) begin errors++;
      $display("FAIL read_capture: got %h expected %h", d, {7'h11, 32'hDEAD_BEEF, 2'd0}); end
    update(2'd2);  // op 0
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL nop_update: got %b expected 0", dmi_req); end
  endtask

  task automatic test_busy;
    logic [40:0] d;
    scan(2'd2, 41, 1'b1, {7'h05, 32'hA5A5_A5A5, 2'd2}, d);
    update(2'd2);
    scan(2'd2, 41, 1'b1, {7'h06, 32'h0000_1234, 2'd1}, d);
    checks++; if (d !== {7'h05, 32'hDEAD_BEEF, 2'd3}) begin errors++;
      $display("FAIL busy_capture_req: got %h expected %h", d, {7'h05, 32'hDEAD_BEEF, 2'd3}); end
    update(2'd2);
    checks++; if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata} !== {1'b1, 1'b1, 7'h05, 32'hA5A5_A5A5}) begin errors++;
      $display("FAIL busy_drop: got req=%b wr=%b addr=%h wdata=%h expected 1 1 05 a5a5a5a5",
               dmi_req, dmi_wr, dmi_addr, dmi_wdata); end
    scan(2'd1, 32, 1'b1, 41'h0, d);
    checks++; if (d[31:0] !== 32'h0000_1C71) begin errors++;
      $display("FAIL busy_dmistat: got %h expected 00001c71", d[31:0]); end
    respond(32'h0);
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL busy_resp: got %b expected 0", dmi_req); end
    scan(2'd2, 41, 1'b1, {7'h07, 32'h0, 2'd1}, d);
    checks++; if (d !== {7'h05, 32'hDEAD_BEEF, 2'd3}) begin errors++;
      $display("FAIL busy_sticky_capture: got %h expected %h", d, {7'h05, 32'hDEAD_BEEF, 2'd3}); end
    update(2'd2);
    checks++; if ({dmi_req, dmi_addr} !== {1'b0, 7'h05}) begin errors++;
      $display("FAIL busy_ignored: got req=%b addr=%h expected 0 05", dmi_req, dmi_addr); end
    scan(2'd1, 32, 1'b1, 41'h0_0001_0000, d);
    update(2'd1);
    scan(2'd2, 41, 1'b1, {7'h07, 32'h0, 2'd1}, d);
    checks++; if (d !== {7'h05, 32'hDEAD_BEEF, 2'd0}) begin errors++;
      $display("FAIL busy_cleared_capture: got %h expected %h", d, {7'h05, 32'hDEAD_BEEF, 2'd0}); end
    update(2'd2);
    checks++; if ({dmi_req, dmi_wr, dmi_addr} !== {1'b1, 1'b0, 7'h07}) begin errors++;
      $display("FAIL busy_cleared_req: got req=%b wr=%b addr=%h expected 1 0 07", dmi_req, dmi_wr, dmi_addr); end
    respond(32'h0BAD_F00D);
  endtask

  task automatic test_update_resp_coincide;
    logic [40:0] d;
    scan(2'd2, 41, 1'b1, {7'h12, 32'h0, 2'd1}, d);
    update(2'd2);
    scan(2'd2, 41, 1'b1, {7'h20, 32'h0000_0055, 2'd2}, d);
    checks++; if (d !== {7'h12, 32'h0BAD_F00D, 2'd3}) begin errors++;
      $display("FAIL coincide_capture: got %h expected %h", d, {7'h12, 32'h0BAD_F00D, 2'd3}); end
    @(negedge clk);
    upd_s = 1'b1; dmi_resp = 1'b1; dmi_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    upd_s = 1'b0; dmi_resp = 1'b0;
    checks++; if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata} !== {1'b1, 1'b1, 7'h20, 32'h55}) begin errors++;
      $display("FAIL coincide_req: got req=%b wr=%b addr=%h wdata=%h expected 1 1 20 00000055",
               dmi_req, dmi_wr, dmi_addr, dmi_wdata); end
    respond(32'h0);
    scan(2'd1, 32, 1'b1, 41'h0, d);
    checks++; if (d[31:0] !== 32'h0000_1071) begin errors++;
      $display("FAIL coincide_no_busy: got %h expected 00001071", d[31:0]); end
    scan(2'd2, 41, 1'b1, 41'h0, d);
    checks++; if (d !== {7'h20, 32'hCAFE_F00D, 2'd0}) begin errors++;
      $display("FAIL coincide_rdata: got %h expected %h", d, {7'h20, 32'hCAFE_F00D, 2'd0}); end
  endtask

  task automatic test_ignored_strobes;
    logic [40:0] d;
    logic [40:0] p;
    p = {7'h2A, 32'h1357_9BDF, 2'd2};
    scan(2'd2, 41, 1'b1, p, d);
    sel = 1'b0; ch_id = 2'd2;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    sel = 1'b1; ch_id = 2'd0;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    ch_id = 2'd3;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL ignored_update: got %b expected 0", dmi_req); end
    scan(2'd2, 41, 1'b0, 41'h0, d);
    checks++; if (d !== p) begin errors++; $display("FAIL ignored_shift_reg: got %h expected %h", d, p); end
  endtask

  task automatic test_reset_in_req;
    logic [40:0] d;
    scan(2'd2, 41, 1'b1, {7'h33, 32'h0, 2'd1}, d);
    update(2'd2);
    checks++; if ({dmi_req, dmi_addr, tdo} !== {1'b1, 7'h33, 1'b1}) begin errors++;
      $display("FAIL rst_pre: got req=%b addr=%h tdo=%b expected 1 33 1", dmi_req, dmi_addr, tdo); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata, tdo} !== 41'h0) begin errors++;
      $display("FAIL rst_async: got req=%b wr=%b addr=%h wdata=%h tdo=%b expected all 0",
               dmi_req, dmi_wr, dmi_addr, dmi_wdata, tdo); end
    @(negedge clk);
    rst_n = 1'b1;
    respond(32'hFFFF_FFFF);
    checks++; if (dmi_req !== 1'b0) begin errors++; $display("FAIL rst_late_resp_req: got %b expected 0", dmi_req); end
    scan(2'd2, 41, 1'b1, 41'h0, d);
    checks++; if (d !== 41'h0) begin errors++; $display("FAIL rst_late_resp_capture: got %h expected 0", d); end
  endtask

  initial begin
    test_reset;
    test_dtmcs_capture;
    test_dmi_write;
    test_dmi_read;
    test_busy;
    test_update_resp_coincide;
    test_ignored_strobes;
    test_reset_in_req;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
